// File: rtl/path_delay_pkg.sv
// rtl/path_delay_pkg.sv - shared types and constants for the path delay monitor
package path_delay_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } pdm_state_e;

   localparam int PDM_CNT_W_DEF = 8;
   localparam int PDM_STAT_W    = 16;

   // Saturating event counter step.
   function automatic logic [PDM_STAT_W-1:0] stat_inc(input logic [PDM_STAT_W-1:0] v,
                                                      input logic                  hit);
      return (hit && (v != '1)) ? v + 1'b1 : v;
   endfunction

endpackage

// File: rtl/pdm_edge_det.sv
// rtl/pdm_edge_det.sv - one-bit toggle detector with previous-level output
module pdm_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic tgl,
   output logic prev
);

   // Reset also loads the live level, so a value held across reset never reads as a toggle.
   always_ff @(posedge clk) begin
      prev <= d;
   end

   assign tgl = ~rst & (d ^ prev);

endmodule

// File: rtl/path_delay_monitor.sv
// rtl/path_delay_monitor.sv - src=>dst path delay checker; optional counters via PATH_DELAY_MONITOR_STATS_EN
module path_delay_monitor
   import path_delay_pkg::*;
#(
   parameter int CNT_W   = PDM_CNT_W_DEF,
   parameter bit POL_NEG = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  src,
   input  logic                  dst,
   input  logic [CNT_W-1:0]      rise_min,
   input  logic [CNT_W-1:0]      rise_max,
   input  logic [CNT_W-1:0]      fall_min,
   input  logic [CNT_W-1:0]      fall_max,
`ifdef PATH_DELAY_MONITOR_STATS_EN
   input  logic                  stats_clr,
   output logic [PDM_STAT_W-1:0] n_meas,
   output logic [PDM_STAT_W-1:0] n_early,
   output logic [PDM_STAT_W-1:0] n_late,
   output logic [PDM_STAT_W-1:0] n_pulse,
`endif
   output logic                  busy,
   output logic                  meas_valid,
   output logic [CNT_W-1:0]      meas_delay,
   output logic                  meas_fall,
   output logic                  viol_early,
   output logic                  viol_late,
   output logic                  pulse_rej
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   pdm_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             exp_q, exp_d;
   logic             lvl0_q, lvl0_d;
   logic             src_e, src_prev;
   logic             dst_e, dst_prev;
   logic             src_exp;
   logic             dst_match;

   logic             done;
   logic             done_tmo;
   logic [CNT_W-1:0] done_delay;
   logic             done_fall;
   logic             rej;
   logic [CNT_W-1:0] lim_min, lim_max;
   logic             early, late;

   pdm_edge_det u_src_det (
      .clk  (clk),
      .rst  (rst),
      .d    (src),
      .tgl  (src_e),
      .prev (src_prev)
   );

   pdm_edge_det u_dst_det (
      .clk  (clk),
      .rst  (rst),
      .d    (dst),
      .tgl  (dst_e),
      .prev (dst_prev)
   );

   assign src_exp = src ^ POL_NEG;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      exp_d      = exp_q;
      lvl0_d     = lvl0_q;
      done       = 1'b0;
      done_tmo   = 1'b0;
      done_delay = count_q;
      done_fall  = ~exp_q;
      rej        = 1'b0;
      // On a toggle the new dst level is the inverse of the previous one.
      dst_match  = dst_e && (~dst_prev == exp_q);

      case (state_q)
         IDLE: begin
            if (src_e) begin
               exp_d  = src_exp;
               lvl0_d = src_prev;
               if (dst_e && (~dst_prev == src_exp)) begin
                  done       = 1'b1;
                  done_delay = '0;
                  done_fall  = ~src_exp;
               end else begin
                  state_d = WAIT;
                  count_d = CNT_ONE;
               end
            end
         end
         WAIT: begin
            if (dst_match) begin
               done = 1'b1;
               // A coincident src toggle opens the next measurement instead of rejecting.
               if (src_e) begin
                  exp_d   = src_exp;
                  lvl0_d  = src_prev;
                  count_d = CNT_ONE;
               end else begin
                  state_d = IDLE;
               end
            end else if (src_e && (src == lvl0_q)) begin
               rej     = 1'b1;
               state_d = IDLE;
            end else if (count_q == CNT_MAX) begin
               done     = 1'b1;
               done_tmo = 1'b1;
               state_d  = IDLE;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign lim_min = done_fall ? fall_min : rise_min;
   assign lim_max = done_fall ? fall_max : rise_max;
   assign early   = done_delay < lim_min;
   assign late    = done_tmo | (done_delay > lim_max);
   assign busy    = (state_q == WAIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         exp_q      <= 1'b0;
         lvl0_q     <= 1'b0;
         meas_valid <= 1'b0;
         meas_delay <= '0;
         meas_fall  <= 1'b0;
         viol_early <= 1'b0;
         viol_late  <= 1'b0;
         pulse_rej  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         exp_q      <= exp_d;
         lvl0_q     <= lvl0_d;
         meas_valid <= done;
         viol_early <= done & early;
         viol_late  <= done & late;
         pulse_rej  <= rej;
         if (done) begin
            meas_delay <= done_delay;
            meas_fall  <= done_fall;
         end
      end
   end

`ifdef PATH_DELAY_MONITOR_STATS_EN
   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         n_meas  <= '0;
         n_early <= '0;
         n_late  <= '0;
         n_pulse <= '0;
      end else begin
         n_meas  <= stat_inc(n_meas,  meas_valid);
         n_early <= stat_inc(n_early, viol_early);
         n_late  <= stat_inc(n_late,  viol_late);
         n_pulse <= stat_inc(n_pulse, pulse_rej);
      end
   end
`endif

endmodule

// File: tb/tb_path_delay_monitor.sv
// tb/tb_path_delay_monitor.sv - directed bench for path_delay_monitor (positive, negative, 4-bit instances)
module tb_path_delay_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       src = 1'b0;
   logic       dst = 1'b0;
   logic [7:0] rise_min = 8'd3, rise_max = 8'd5, fall_min = 8'd2, fall_max = 8'd6;
   logic       stats_clr = 1'b0;

   logic       p_busy, p_valid, p_fall, p_early, p_late, p_rej;
   logic [7:0] p_delay;
   logic       n_busy, n_valid, n_fall, n_early, n_late, n_rej;
   logic [7:0] n_delay;
   logic       w_busy, w_valid, w_fall, w_early, w_late, w_rej;
   logic [3:0] w_delay;
`ifdef PATH_DELAY_MONITOR_STATS_EN
   logic [15:0] p_nm, p_ne, p_nl, p_np, n_nm, n_ne, n_nl, n_np, w_nm, w_ne, w_nl, w_np;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic strobes;

   always #5 clk = ~clk;

   path_delay_monitor #(.CNT_W(8), .POL_NEG(1'b0)) u_pos (
      .clk(clk), .rst(rst), .src(src), .dst(dst),
      .rise_min(rise_min), .rise_max(rise_max), .fall_min(fall_min), .fall_max(fall_max),
`ifdef PATH_DELAY_MONITOR_STATS_EN
      .stats_clr(stats_clr), .n_meas(p_nm), .n_early(p_ne), .n_late(p_nl), .n_pulse(p_np),
`endif
      .busy(p_busy), .meas_valid(p_valid), .meas_delay(p_delay), .meas_fall(p_fall),
      .viol_early(p_early), .viol_late(p_late), .pulse_rej(p_rej)
   );

   path_delay_monitor #(.CNT_W(8), .POL_NEG(1'b1)) u_neg (
      .clk(clk), .rst(rst), .src(src), .dst(dst),
      .rise_min(rise_min), .rise_max(rise_max), .fall_min(fall_min), .fall_max(fall_max),
`ifdef PATH_DELAY_MONITOR_STATS_EN
      .stats_clr(stats_clr), .n_meas(n_nm), .n_early(n_ne), .n_late(n_nl), .n_pulse(n_np),
`endif
      .busy(n_busy), .meas_valid(n_valid), .meas_delay(n_delay), .meas_fall(n_fall),
      .viol_early(n_early), .viol_late(n_late), .pulse_rej(n_rej)
   );

   path_delay_monitor #(.CNT_W(4), .POL_NEG(1'b0)) u_w4 (
      .clk(clk), .rst(rst), .src(src), .dst(dst),
      .rise_min(rise_min[3:0]), .rise_max(rise_max[3:0]),
      .fall_min(fall_min[3:0]), .fall_max(fall_max[3:0]),
`ifdef PATH_DELAY_MONITOR_STATS_EN
      .stats_clr(stats_clr), .n_meas(w_nm), .n_early(w_ne), .n_late(w_nl), .n_pulse(w_np),
`endif
      .busy(w_busy), .meas_valid(w_valid), .meas_delay(w_delay), .meas_fall(w_fall),
      .viol_early(w_early), .viol_late(w_late), .pulse_rej(w_rej)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic s, input logic d);
      rst = 1'b1;
      src = s;
      dst = d;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(1'b0, 1'b0);
      n_vec++;
      if ({p_busy, p_valid, p_fall, p_early, p_late, p_rej} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_flags got %b exp 000000", {p_busy, p_valid, p_fall, p_early, p_late, p_rej});
      end
      n_vec++;
      if (p_delay !== 8'd0) begin
         n_err++;
         $display("FAIL reset_delay got %0d exp 0", p_delay);
      end
   endtask

   task automatic test_positive();
      do_reset(1'b0, 1'b0);
      src = 1'b1;
      step();
      n_vec++;
      if (p_busy !== 1'b1) begin
         n_err++;
         $display("FAIL pos_busy got %b exp 1", p_busy);
      end
      repeat (3) step();
      dst = 1'b1;
      step();
      n_vec++;
      if ({p_valid, p_fall, p_early, p_late} !== 4'b1000) begin
         n_err++;
         $display("FAIL pos_flags got %b exp 1000", {p_valid, p_fall, p_early, p_late});
      end
      n_vec++;
      if (p_delay !== 8'd4) begin
         n_err++;
         $display("FAIL pos_delay got %0d exp 4", p_delay);
      end
      step();
      n_vec++;
      if ({p_valid, p_busy, p_delay} !== {1'b0, 1'b0, 8'd4}) begin
         n_err++;
         $display("FAIL pos_hold got v=%b b=%b d=%0d exp v=0 b=0 d=4", p_valid, p_busy, p_delay);
      end

      // Delay 6 against rise_max 5 is late.
      do_reset(1'b0, 1'b0);
      src = 1'b1;
      repeat (6) step();
      dst = 1'b1;
      step();
      n_vec++;
      if ({p_valid, p_early, p_late, p_delay} !== {3'b101, 8'd6}) begin
         n_err++;
         $display("FAIL pos_late got v=%b e=%b l=%b d=%0d exp v=1 e=0 l=1 d=6", p_valid, p_early, p_late, p_delay);
      end

      // Raising rise_max mid-measurement applies, since limits are taken at completion.
      do_reset(1'b0, 1'b0);
      src = 1'b1;
      repeat (3) step();
      rise_max = 8'd7;
      repeat (3) step();
      dst = 1'b1;
      step();
      n_vec++;
      if ({p_valid, p_early, p_late, p_delay} !== {3'b100, 8'd6}) begin
         n_err++;
         $display("FAIL pos_live_limit got v=%b e=%b l=%b d=%0d exp v=1 e=0 l=0 d=6", p_valid, p_early, p_late, p_delay);
      end
      rise_max = 8'd5;
   endtask

   task automatic test_negative();
      do_reset(1'b0, 1'b1);
      src = 1'b1;
      step();
      dst = 1'b0;
      step();
      n_vec++;
      if ({n_valid, n_fall, n_early, n_late} !== 4'b1110) begin
         n_err++;
         $display("FAIL neg_flags got %b exp 1110", {n_valid, n_fall, n_early, n_late});
      end
      n_vec++;
      if (n_delay !== 8'd1) begin
         n_err++;
         $display("FAIL neg_delay got %0d exp 1", n_delay);
      end
   endtask

   task automatic test_pulse_reject();
      do_reset(1'b0, 1'b0);
      src = 1'b1;
      repeat (2) step();
      src = 1'b0;
      step();
      n_vec++;
      if ({p_rej, p_valid, p_busy} !== 3'b100) begin
         n_err++;
         $display("FAIL pulse_rej got rej=%b v=%b busy=%b exp 1 0 0", p_rej, p_valid, p_busy);
      end
      step();
      n_vec++;
      if ({p_rej, p_valid, p_busy} !== 3'b000) begin
         n_err++;
         $display("FAIL pulse_once got rej=%b v=%b busy=%b exp 0 0 0", p_rej, p_valid, p_busy);
      end
   endtask

   task automatic test_timeout();
      do_reset(1'b0, 1'b0);
      src = 1'b1;
      repeat (15) step();
      n_vec++;
      if ({w_valid, w_busy} !== 2'b01) begin
         n_err++;
         $display("FAIL tmo_early got v=%b busy=%b exp v=0 busy=1", w_valid, w_busy);
      end
      step();
      n_vec++;
      if ({w_valid, w_late, w_early, w_fall, w_delay} !== {4'b1100, 4'hF}) begin
         n_err++;
         $display("FAIL tmo_strobe got v=%b l=%b e=%b f=%b d=%h exp v=1 l=1 e=0 f=0 d=f", w_valid, w_late, w_early, w_fall, w_delay);
      end
      step();
      n_vec++;
      if ({w_valid, w_busy} !== 2'b00) begin
         n_err++;
         $display("FAIL tmo_idle got v=%b busy=%b exp 0 0", w_valid, w_busy);
      end
   endtask

   task automatic test_reset_abort();
      do_reset(1'b0, 1'b0);
      src = 1'b1;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      strobes = 1'b0;
      step();
      strobes |= p_valid | p_rej | p_early | p_late | p_busy;
      dst = 1'b1;
      repeat (4) begin
         step();
         strobes |= p_valid | p_rej | p_early | p_late | p_busy;
      end
      n_vec++;
      if (strobes !== 1'b0) begin
         n_err++;
         $display("FAIL rst_abort got activity=%b exp 0", strobes);
      end
   endtask

   task automatic test_same_cycle();
      do_reset(1'b0, 1'b0);
      src = 1'b1;
      dst = 1'b1;
      step();
      n_vec++;
      if ({p_valid, p_early, p_late, p_fall, p_busy, p_delay} !== {5'b11000, 8'd0}) begin
         n_err++;
         $display("FAIL same_cycle got v=%b e=%b l=%b f=%b b=%b d=%0d exp 1 1 0 0 0 0", p_valid, p_early, p_late, p_fall, p_busy, p_delay);
      end
`ifdef PATH_DELAY_MONITOR_STATS_EN
      step();
      n_vec++;
      if ({p_nm, p_ne, p_nl, p_np} !== {16'd1, 16'd1, 16'd0, 16'd0}) begin
         n_err++;
         $display("FAIL stats_count got m=%0d e=%0d l=%0d p=%0d exp 1 1 0 0", p_nm, p_ne, p_nl, p_np);
      end
      stats_clr = 1'b1;
      step();
      stats_clr = 1'b0;
      n_vec++;
      if ({p_nm, p_ne, p_nl, p_np} !== 64'd0) begin
         n_err++;
         $display("FAIL stats_clr got m=%0d e=%0d l=%0d p=%0d exp 0 0 0 0", p_nm, p_ne, p_nl, p_np);
      end
`endif
   endtask

   task automatic test_back_to_back();
      do_reset(1'b0, 1'b0);
      src = 1'b1;
      repeat (3) step();
      src = 1'b0;
      dst = 1'b1;
      step();
      n_vec++;
      if ({p_valid, p_rej, p_busy, p_fall, p_delay} !== {4'b1010, 8'd3}) begin
         n_err++;
         $display("FAIL b2b_first got v=%b r=%b b=%b f=%b d=%0d exp 1 0 1 0 3", p_valid, p_rej, p_busy, p_fall, p_delay);
      end
      step();
      dst = 1'b0;
      step();
      n_vec++;
      if ({p_valid, p_fall, p_early, p_late, p_delay} !== {4'b1100, 8'd2}) begin
         n_err++;
         $display("FAIL b2b_second got v=%b f=%b e=%b l=%b d=%0d exp 1 1 0 0 2", p_valid, p_fall, p_early, p_late, p_delay);
      end
   endtask

   initial begin
      test_reset();
      test_positive();
      test_negative();
      test_pulse_reject();
      test_timeout();
      test_reset_abort();
      test_same_cycle();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/path_delay_monitor.md
Name: path_delay_monitor

Overview:
- Runtime checker for module path delays (src => dst) declared in specify blocks: measures, in clk cycles, the time from a source transition to the matching destination transition and checks it against rise/fall min/max limits.
- Detects pulse rejection: source re-toggles before the destination responds, the PATHPULSE-style case.
- Sits in the verification/sign-off fabric beside the DUT path it observes. Inputs are already synchronous to clk.

Parameters:
- CNT_W, 8, width of delay counter and limit inputs; count saturates at 2**CNT_W-1
- POL_NEG, 0, path polarity: 0 = positive (src rise => dst rise), 1 = negative (src rise => dst fall)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- src  in  1  path source sample
- dst  in  1  path destination sample
- rise_min  in  CNT_W  min allowed delay, dst rising transition
- rise_max  in  CNT_W  max allowed delay, dst rising transition
- fall_min  in  CNT_W  min allowed delay, dst falling transition
- fall_max  in  CNT_W  max allowed delay, dst falling transition
- busy  out  1  measurement in progress
- meas_valid  out  1  one-cycle strobe, measurement complete
- meas_delay  out  CNT_W  measured delay, held until next meas_valid
- meas_fall  out  1  1 = measured dst transition was falling
- viol_early  out  1  one-cycle strobe with meas_valid, delay < min
- viol_late  out  1  one-cycle strobe, delay > max or timeout
- pulse_rej  out  1  one-cycle strobe, source pulse swallowed before dst responded

Behaviour:
- Reset: src_q/dst_q load current src/dst; state IDLE; count 0. All outputs 0, meas_delay 0.
- Edge detect: src_e = src ^ src_q, dst_e = dst ^ dst_q. src_q/dst_q update every cycle.
- Expected dst level: exp = src ^ POL_NEG, latched on each src edge.
- IDLE:
  - src_e: latch exp, latch src_lvl0 = src_q.
  - dst_e same cycle with dst == exp: complete with delay 0.
  - Otherwise go to WAIT with count = 1.
  - dst_e without a preceding src edge is ignored.
- WAIT (busy = 1):
  - dst_e with dst == exp: complete with delay = count, go IDLE.
  - src_e with src == src_lvl0 (no dst edge this cycle): pulse_rej = 1, no meas_valid, go IDLE.
  - src_e and dst_e in the same cycle: the dst completion wins and is reported. The src edge then starts a new measurement the next cycle (re-enter WAIT, count = 1). It is not a pulse reject.
  - count == 2**CNT_W-1 with no dst edge: timeout. meas_valid = 1, viol_late = 1, meas_delay = all-ones, meas_fall = ~exp, go IDLE.
  - Otherwise count++.
- Completion, single cycle, registered outputs (one cycle after the completing sample):
  - meas_valid = 1; meas_delay = count; meas_fall = ~exp.
  - Limit select: (fall_min, fall_max) if meas_fall, else (rise_min, rise_max).
  - viol_early = delay < min; viol_late = delay > max. Unsigned compare.
  - min > max: both flags may assert. No error beyond that.
- Limit inputs are sampled at completion, not at the start of measurement.
- rst mid-measurement: abort, no strobes, state IDLE. src_q/dst_q reload, so a level held across reset is not an edge.

Optional Feature:
- Macro: PATH_DELAY_MONITOR_STATS_EN.
- Defined: adds outputs n_meas, n_early, n_late, n_pulse, each 16-bit out, plus input stats_clr (1-bit, synchronous, clears all four).
  - Counters increment on the matching strobe and saturate at 16'hFFFF.
  - Reset value 0.
  - stats_clr and an increment in the same cycle: clear wins.
- Undefined: the ports and logic are absent; behaviour otherwise identical.

Decomposition:
- Package path_delay_pkg holds:
  - state enum (IDLE, WAIT)
  - default CNT_W
  - stats counter width (16)
- One sub-module, pdm_edge_det: registers a 1-bit input, outputs edge and previous level. Reset loads the current input.
- Instantiate pdm_edge_det twice (src, dst).

Test Plan:
- Positive path, limits rise 3..5: src rises, dst rises 4 cycles later -> meas_valid, meas_delay=4, meas_fall=0, no viol.
- POL_NEG=1, fall limits 2..6: src rises, dst falls 1 cycle later -> meas_delay=1, meas_fall=1, viol_early=1.
- src high for 2 cycles then low, dst static -> pulse_rej=1 once, no meas_valid, busy returns 0.
- CNT_W=4, src rises, dst never moves -> after 15 counts meas_valid=1, viol_late=1, meas_delay=4'hF.
- rst asserted at count 3 of a measurement, dst rises 2 cycles later -> no strobes at all.
- src and dst toggle in the same cycle while IDLE -> meas_delay=0. With STATS_EN, n_meas=1, then stats_clr -> all four counters 0.
